// File: rtl/branch_unit_pkg.sv
// Shared definitions for the branch unit: condition codes (also used by the
// decoder) and the condition evaluator for flag-based jumps.
package branch_unit_pkg;

  // Condition codes carried on br_cond. Codes 10-15 behave as COND_NONE.
  localparam logic [3:0] COND_NONE = 4'd0;
  localparam logic [3:0] COND_JMP  = 4'd1;
  localparam logic [3:0] COND_JE   = 4'd2;
  localparam logic [3:0] COND_JNE  = 4'd3;
  localparam logic [3:0] COND_JB   = 4'd4;
  localparam logic [3:0] COND_JAE  = 4'd5;
  localparam logic [3:0] COND_JA   = 4'd6;
  localparam logic [3:0] COND_JBE  = 4'd7;
  localparam logic [3:0] COND_CALL = 4'd8;
  localparam logic [3:0] COND_RET  = 4'd9;

  // True when a plain jump (unconditional or flag-conditional) is taken.
  // CALL and RET redirect through their own paths and return 0 here.
  function automatic logic cond_taken(input logic [3:0] cond,
                                      input logic       zf,
                                      input logic       cf);
    logic taken;
    taken = 1'b0;
    case (cond)
      COND_JMP: taken = 1'b1;
      COND_JE:  taken = zf;
      COND_JNE: taken = !zf;
      COND_JB:  taken = cf;
      COND_JAE: taken = !cf;
      COND_JA:  taken = !cf && !zf;
      COND_JBE: taken = cf || zf;
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_unit_return_stack.sv
// Circular return-address stack. Pushing onto a full stack overwrites the
// oldest entry (the write pointer has wrapped onto it) and keeps the count
// saturated; popping an empty stack is ignored. Both cases are flagged
// combinationally so the owner can register an error pulse.
module return_stack #(
  parameter int AW        = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_push_data,
  output logic [AW-1:0] o_top,
  output logic          o_empty,
  output logic          o_overflow,
  output logic          o_underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0] r_ptr;    // next free slot; top of stack is r_ptr-1
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_do_pop;
  logic [PW-1:0] w_top_idx;

  assign w_full      = (r_count == CW'(RAS_DEPTH));
  assign o_empty     = (r_count == '0);
  assign w_do_pop    = i_pop && !o_empty;
  assign w_top_idx   = r_ptr - PW'(1);
  assign o_top       = r_mem[w_top_idx];
  assign o_overflow  = i_push && w_full;
  assign o_underflow = i_pop && o_empty;

  // Entry storage: written on push only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy; push takes priority if both were ever requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!w_full) begin
        r_count <= r_count + CW'(1);
      end
    end else if (w_do_pop) begin
      r_ptr   <= r_ptr - PW'(1);
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/branch_unit.sv
// Branch unit: architectural ZF/CF register, condition evaluation with a
// same-cycle flag bypass, program counter, return-address stack, and the
// registered flush / stack-error pulses sent to fetch and decode.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int          AW        = 16,
  parameter int unsigned RESET_PC  = 0,
  parameter int          RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flag_we,
  input  logic          zf_in,
  input  logic          cf_in,
  input  logic          br_valid,
  input  logic [3:0]    br_cond,
  input  logic [AW-1:0] br_target,
  output logic [AW-1:0] pc,
  output logic          zf,
  output logic          cf,
  output logic          flush,
  output logic          stack_err
);

  logic [AW-1:0] r_pc;
  logic          r_zf;
  logic          r_cf;
  logic          r_flush;
  logic          r_stack_err;

  logic          w_zf_eff;
  logic          w_cf_eff;
  logic          w_is_call;
  logic          w_is_ret;
  logic          w_jump;
  logic          w_push;
  logic          w_pop;
  logic          w_ras_empty;
  logic          w_ras_ovf;
  logic          w_ras_unf;
  logic [AW-1:0] w_ras_top;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_pc_next;
  logic          w_redirect;

  // A compare issued in the same cycle as the jump must steer it, so the
  // incoming flags bypass the register while flag_we is high.
  assign w_zf_eff = flag_we ? zf_in : r_zf;
  assign w_cf_eff = flag_we ? cf_in : r_cf;

  assign w_is_call = br_valid && (br_cond == COND_CALL);
  assign w_is_ret  = br_valid && (br_cond == COND_RET);
  assign w_jump    = br_valid && cond_taken(br_cond, w_zf_eff, w_cf_eff);

  // The stack only moves on edges where the pipeline advances.
  assign w_push = !stall && w_is_call;
  assign w_pop  = !stall && w_is_ret;

  assign w_pc_inc = r_pc + AW'(1);

  return_stack #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_pc_inc),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty),
    .o_overflow  (w_ras_ovf),
    .o_underflow (w_ras_unf)
  );

  // Next-pc select; any load from br_target or the stack counts as a redirect,
  // even when the target happens to equal pc+1.
  always_comb begin
    w_pc_next  = w_pc_inc;
    w_redirect = 1'b0;
    if (w_jump || w_is_call) begin
      w_pc_next  = br_target;
      w_redirect = 1'b1;
    end else if (w_is_ret && !w_ras_empty) begin
      w_pc_next  = w_ras_top;
      w_redirect = 1'b1;
    end
  end

  // Architectural flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zf <= 1'b0;
      r_cf <= 1'b0;
    end else if (!stall && flag_we) begin
      r_zf <= zf_in;
      r_cf <= cf_in;
    end
  end

  // Program counter; holds during stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= AW'(RESET_PC);
    end else if (!stall) begin
      r_pc <= w_pc_next;
    end
  end

  // One-cycle flush and stack-error pulses, suppressed on stalled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush     <= 1'b0;
      r_stack_err <= 1'b0;
    end else if (stall) begin
      r_flush     <= 1'b0;
      r_stack_err <= 1'b0;
    end else begin
      r_flush     <= w_redirect;
      r_stack_err <= w_ras_ovf || w_ras_unf;
    end
  end

  assign pc        = r_pc;
  assign zf        = r_zf;
  assign cf        = r_cf;
  assign flush     = r_flush;
  assign stack_err = r_stack_err;

endmodule
